// File: rtl/bmp280_pkg.sv
// bmp280_pkg: BMP280 register map, soft-reset word and responder state type
package bmp280_pkg;
  localparam logic [7:0] ADDR_ID         = 8'hD0;
  localparam logic [7:0] ADDR_RESET      = 8'hE0;
  localparam logic [7:0] ADDR_STATUS     = 8'hF3;
  localparam logic [7:0] ADDR_CTRL_MEAS  = 8'hF4;
  localparam logic [7:0] ADDR_CONFIG     = 8'hF5;
  localparam logic [7:0] ADDR_PRESS_MSB  = 8'hF7;
  localparam logic [7:0] ADDR_PRESS_LSB  = 8'hF8;
  localparam logic [7:0] ADDR_PRESS_XLSB = 8'hF9;
  localparam logic [7:0] ADDR_TEMP_MSB   = 8'hFA;
  localparam logic [7:0] ADDR_TEMP_LSB   = 8'hFB;
  localparam logic [7:0] ADDR_TEMP_XLSB  = 8'hFC;
  localparam logic [7:0] ADDR_CALIB_LO   = 8'h88;
  localparam logic [7:0] ADDR_CALIB_HI   = 8'h9F;
  localparam logic [7:0] RESET_WORD      = 8'hB6;
  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} resp_state_t;
  function automatic logic [7:0] raw_byte(input logic [19:0] raw, input logic [1:0] sel);
    return sel == 2'd0 ? raw[19:12] : sel == 2'd1 ? raw[11:4] : {raw[3:0], 4'h0};
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: DEPTH-flop synchronizer with registered-history rise/fall pulses
module spi_sync_edge #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [DEPTH:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[DEPTH-1:0], d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign q    = sync_q[DEPTH-1];
  assign rise = sync_q[DEPTH-1] & ~sync_q[DEPTH];
  assign fall = ~sync_q[DEPTH-1] & sync_q[DEPTH];
endmodule

// File: rtl/bmp280_spi_responder.sv
// bmp280_spi_responder: SPI mode-0 slave emulating the BMP280 register interface
// BMP280_RESP_SHADOW_EN: capture press_raw/temp_raw at ss fall for coherent burst reads
module bmp280_spi_responder
  import bmp280_pkg::*;
#(
  parameter logic [7:0] CHIP_ID    = 8'h58,
  parameter int         SYNC_DEPTH = 2
) (
  input  logic         mclk,
  input  logic         rst_n,
  input  logic         spi_clk,
  input  logic         spi_mosi,
  input  logic         spi_ss,
  output logic         spi_miso,
  output logic         spi_miso_oe,
  input  logic [19:0]  press_raw,
  input  logic [19:0]  temp_raw,
  input  logic [191:0] calib,
  input  logic         measuring,
  input  logic         im_update,
  output logic [7:0]   ctrl_meas,
  output logic [7:0]   config_reg,
  output logic         soft_rst
);
  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic mosi, mosi_rise_unused, mosi_fall_unused;
  logic ss_rise, ss_fall, ss_lvl_unused;
  spi_sync_edge #(.DEPTH(SYNC_DEPTH)) u_sclk (
    .clk(mclk), .rst_n(rst_n), .d(spi_clk), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.DEPTH(SYNC_DEPTH)) u_mosi (
    .clk(mclk), .rst_n(rst_n), .d(spi_mosi), .q(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused));
  // ss resets to the low level, so ss held low through reset never yields a falling edge
  spi_sync_edge #(.DEPTH(SYNC_DEPTH)) u_ss (
    .clk(mclk), .rst_n(rst_n), .d(spi_ss), .q(ss_lvl_unused), .rise(ss_rise), .fall(ss_fall));
  resp_state_t state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_in_q, sh_in_d, sh_out_q, sh_out_d, addr_q, addr_d;
  logic [7:0] ctrl_q, ctrl_d, cfg_q, cfg_d;
  logic load_q, load_d, miso_q, miso_d, srst_q, srst_d;
  logic [7:0] byte_in, rd_data;
  logic [19:0] press_src, temp_src;
  logic [4:0] calib_k;
`ifdef BMP280_RESP_SHADOW_EN
  logic [19:0] press_sh_q, press_sh_d, temp_sh_q, temp_sh_d;
  always_comb begin
    press_sh_d = (state_q == IDLE && ss_fall) ? press_raw : press_sh_q;
    temp_sh_d  = (state_q == IDLE && ss_fall) ? temp_raw : temp_sh_q;
  end
  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) begin
      press_sh_q <= '0;
      temp_sh_q  <= '0;
    end else begin
      press_sh_q <= press_sh_d;
      temp_sh_q  <= temp_sh_d;
    end
  assign press_src = press_sh_q;
  assign temp_src  = temp_sh_q;
`else
  assign press_src = press_raw;
  assign temp_src  = temp_raw;
`endif
  assign calib_k = 5'(addr_q - ADDR_CALIB_LO);
  always_comb begin
    rd_data = 8'h00;
    if (addr_q >= ADDR_CALIB_LO && addr_q <= ADDR_CALIB_HI) rd_data = calib[{calib_k, 3'b000} +: 8];
    case (addr_q)
      ADDR_ID:         rd_data = CHIP_ID;
      ADDR_STATUS:     rd_data = {4'b0, measuring, 2'b0, im_update};
      ADDR_CTRL_MEAS:  rd_data = ctrl_q;
      ADDR_CONFIG:     rd_data = cfg_q;
      ADDR_PRESS_MSB:  rd_data = raw_byte(press_src, 2'd0);
      ADDR_PRESS_LSB:  rd_data = raw_byte(press_src, 2'd1);
      ADDR_PRESS_XLSB: rd_data = raw_byte(press_src, 2'd2);
      ADDR_TEMP_MSB:   rd_data = raw_byte(temp_src, 2'd0);
      ADDR_TEMP_LSB:   rd_data = raw_byte(temp_src, 2'd1);
      ADDR_TEMP_XLSB:  rd_data = raw_byte(temp_src, 2'd2);
      default: ;
    endcase
  end
  assign byte_in = {sh_in_q[6:0], mosi};
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_in_d   = sh_in_q;
    sh_out_d  = sh_out_q;
    addr_d    = addr_q;
    load_d    = load_q;
    miso_d    = miso_q;
    ctrl_d    = srst_q ? 8'h00 : ctrl_q;
    cfg_d     = srst_q ? 8'h00 : cfg_q;
    srst_d    = 1'b0;
    if (ss_rise) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      load_d  = 1'b0;
    end else if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d   = CMD;
        bit_cnt_d = 3'd0;
        addr_d    = 8'h00;
        miso_d    = 1'b0;
        load_d    = 1'b0;
      end
    end else if (sclk_rise) begin
      sh_in_d   = byte_in;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7)
        case (state_q)
          CMD: begin
            state_d = byte_in[7] ? RDATA : WDATA;
            addr_d  = {1'b1, byte_in[6:0]};
            load_d  = byte_in[7];
          end
          WDATA: begin
            state_d = CMD;
            ctrl_d  = addr_q == ADDR_CTRL_MEAS ? byte_in : ctrl_d;
            cfg_d   = addr_q == ADDR_CONFIG ? byte_in : cfg_d;
            srst_d  = addr_q == ADDR_RESET && byte_in == RESET_WORD;
          end
          RDATA: begin
            addr_d = addr_q + 8'd1;
            load_d = 1'b1;
          end
          default: ;
        endcase
    end else if (sclk_fall && state_q == RDATA) begin
      miso_d   = load_q ? rd_data[7] : sh_out_q[7];
      sh_out_d = load_q ? {rd_data[6:0], 1'b0} : {sh_out_q[6:0], 1'b0};
      load_d   = 1'b0;
    end
  end
  always_ff @(posedge mclk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      sh_in_q   <= 8'h00;
      sh_out_q  <= 8'h00;
      addr_q    <= 8'h00;
      load_q    <= 1'b0;
      miso_q    <= 1'b0;
      ctrl_q    <= 8'h00;
      cfg_q     <= 8'h00;
      srst_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_in_q   <= sh_in_d;
      sh_out_q  <= sh_out_d;
      addr_q    <= addr_d;
      load_q    <= load_d;
      miso_q    <= miso_d;
      ctrl_q    <= ctrl_d;
      cfg_q     <= cfg_d;
      srst_q    <= srst_d;
    end
  assign spi_miso    = miso_q;
  assign spi_miso_oe = state_q != IDLE && !ss_rise;
  assign ctrl_meas   = ctrl_q;
  assign config_reg  = cfg_q;
  assign soft_rst    = srst_q;
endmodule

// File: tb/tb_bmp280_spi_responder.sv
// tb_bmp280_spi_responder: table-driven register vectors plus hand-written SPI corner cases
module tb_bmp280_spi_responder;
  logic mclk = 1'b0, rst_n = 1'b0, spi_clk = 1'b0, spi_mosi = 1'b0, spi_ss = 1'b1;
  logic spi_miso, spi_miso_oe, soft_rst, measuring = 1'b1, im_update = 1'b0;
  logic [19:0] press_raw = 20'hABCDE, temp_raw = 20'h12345;
  logic [191:0] calib;
  logic [7:0] ctrl_meas, config_reg, rx, cfg_keep;
  int errors = 0, checks = 0, pulse_cnt = 0;
  bmp280_spi_responder dut (
    .mclk(mclk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_ss(spi_ss),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .press_raw(press_raw), .temp_raw(temp_raw),
    .calib(calib), .measuring(measuring), .im_update(im_update), .ctrl_meas(ctrl_meas),
    .config_reg(config_reg), .soft_rst(soft_rst));
  always #5 mclk = ~mclk;
  always @(negedge mclk) if (soft_rst) pulse_cnt++;
  typedef struct {
    string name;
    logic [7:0] cmd, tx, exp_rx;
    logic chk_rx;
    logic [7:0] exp_ctrl, exp_cfg;
  } vec_t;
  vec_t v[15];
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask
  task automatic xbits(input logic [7:0] tx, input int n, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      #80;
      r[i] = spi_miso;
      spi_clk = 1'b1;
      #80;
      spi_clk = 1'b0;
    end
  endtask
  task automatic ss_lo; spi_ss = 1'b0; #80; endtask
  task automatic ss_hi; #80; spi_ss = 1'b1; #160; endtask
  task automatic xfer2(input logic [7:0] cmd, input logic [7:0] tx, output logic [7:0] r);
    logic [7:0] dummy;
    ss_lo();
    xbits(cmd, 8, dummy);
    xbits(tx, 8, r);
    ss_hi();
  endtask
  initial begin
    for (int k = 0; k < 24; k++) calib[8*k +: 8] = 8'(8'hA0 + k);
    v[0]  = '{"rd_id",       8'hD0, 8'h00, 8'h58, 1'b1, 8'h00, 8'h00};
    v[1]  = '{"wr_f4",       8'h74, 8'h27, 8'h00, 1'b0, 8'h27, 8'h00};
    v[2]  = '{"rd_f4",       8'hF4, 8'h00, 8'h27, 1'b1, 8'h27, 8'h00};
    v[3]  = '{"wr_f5",       8'h75, 8'hA5, 8'h00, 1'b0, 8'h27, 8'hA5};
    v[4]  = '{"rd_f5",       8'hF5, 8'h00, 8'hA5, 1'b1, 8'h27, 8'hA5};
    v[5]  = '{"rd_status",   8'hF3, 8'h00, 8'h08, 1'b1, 8'h27, 8'hA5};
    v[6]  = '{"rd_calib_lo", 8'h88, 8'h00, 8'hA0, 1'b1, 8'h27, 8'hA5};
    v[7]  = '{"rd_calib_hi", 8'h9F, 8'h00, 8'hB7, 1'b1, 8'h27, 8'hA5};
    v[8]  = '{"rd_a0",       8'hA0, 8'h00, 8'h00, 1'b1, 8'h27, 8'hA5};
    v[9]  = '{"rd_87",       8'h87, 8'h00, 8'h00, 1'b1, 8'h27, 8'hA5};
    v[10] = '{"rd_e0",       8'hE0, 8'h00, 8'h00, 1'b1, 8'h27, 8'hA5};
    v[11] = '{"rd_f9",       8'hF9, 8'h00, 8'hE0, 1'b1, 8'h27, 8'hA5};
    v[12] = '{"rd_fc",       8'hFC, 8'h00, 8'h50, 1'b1, 8'h27, 8'hA5};
    v[13] = '{"wr_f6_ign",   8'h76, 8'h11, 8'h00, 1'b0, 8'h27, 8'hA5};
    v[14] = '{"wr_e0_55",    8'h60, 8'h55, 8'h00, 1'b0, 8'h27, 8'hA5};
    #52;
    check("rst_miso", {7'b0, spi_miso}, 8'h00);
    check("rst_oe", {7'b0, spi_miso_oe}, 8'h00);
    check("rst_ctrl", ctrl_meas, 8'h00);
    check("rst_cfg", config_reg, 8'h00);
    check("rst_srst", {7'b0, soft_rst}, 8'h00);
    rst_n = 1'b1;
    #100;
    ss_lo();
    check("oe_active", {7'b0, spi_miso_oe}, 8'h01);
    xbits(8'hD0, 8, rx);
    xbits(8'h00, 8, rx);
    check("oe_rd_id", rx, 8'h58);
    #80;
    spi_ss = 1'b1;
    #40;
    check("oe_drop", {7'b0, spi_miso_oe}, 8'h00);
    #120;
    for (int i = 0; i < 15; i++) begin
      xfer2(v[i].cmd, v[i].tx, rx);
      if (v[i].chk_rx) check(v[i].name, rx, v[i].exp_rx);
      check({v[i].name, "_ctrl"}, ctrl_meas, v[i].exp_ctrl);
      check({v[i].name, "_cfg"}, config_reg, v[i].exp_cfg);
    end
    check("no_pulse_55", pulse_cnt[7:0], 8'h00);
    ss_lo();
    xbits(8'hF7, 8, rx);
    xbits(8'h00, 8, rx); check("burst0", rx, 8'hAB);
    xbits(8'h00, 8, rx); check("burst1", rx, 8'hCD);
    xbits(8'h00, 8, rx); check("burst2", rx, 8'hE0);
    xbits(8'h00, 8, rx); check("burst3", rx, 8'h12);
    xbits(8'h00, 8, rx); check("burst4", rx, 8'h34);
    xbits(8'h00, 8, rx); check("burst5", rx, 8'h50);
    ss_hi();
    xfer2(8'h60, 8'hB6, rx);
    check("srst_pulse", pulse_cnt[7:0], 8'h01);
    check("srst_ctrl", ctrl_meas, 8'h00);
    check("srst_cfg", config_reg, 8'h00);
    xfer2(8'h60, 8'h55, rx);
    check("srst_55", pulse_cnt[7:0], 8'h01);
    xfer2(8'h75, 8'h11, rx);
    cfg_keep = config_reg;
    check("cfg_11", cfg_keep, 8'h11);
    ss_lo();
    xbits(8'h75, 8, rx);
    xbits(8'h3C, 4, rx);
    ss_hi();
    check("partial_cfg", config_reg, 8'h11);
    check("partial_oe", {7'b0, spi_miso_oe}, 8'h00);
    xfer2(8'hD0, 8'h00, rx);
    check("partial_rd_id", rx, 8'h58);
    spi_mosi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #80;
      spi_clk = ~spi_clk;
    end
    #80;
    check("sclk_hi_cfg", config_reg, 8'h11);
    check("sclk_hi_oe", {7'b0, spi_miso_oe}, 8'h00);
    xfer2(8'hD0, 8'h00, rx);
    check("sclk_hi_rd_id", rx, 8'h58);
    ss_lo();
    xbits(8'hF7, 8, rx);
    xbits(8'h00, 8, rx); check("shadow0", rx, 8'hAB);
    press_raw = 20'h13579;
    xbits(8'h00, 8, rx);
`ifdef BMP280_RESP_SHADOW_EN
    check("shadow1", rx, 8'hCD);
    xbits(8'h00, 8, rx); check("shadow2", rx, 8'hE0);
`else
    check("live1", rx, 8'h57);
    xbits(8'h00, 8, rx); check("live2", rx, 8'h90);
`endif
    ss_hi();
    rst_n = 1'b0;
    spi_ss = 1'b0;
    #100;
    rst_n = 1'b1;
    #100;
    xbits(8'h74, 8, rx);
    xbits(8'hFF, 8, rx);
    ss_hi();
    check("rst_ss_low_ctrl", ctrl_meas, 8'h00);
    xfer2(8'hD0, 8'h00, rx);
    check("rst_ss_low_rd_id", rx, 8'h58);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
